vga_scanout: RTL and testbench

//  Display-side consumer of the pixel FIFO, running in the pixel-clock domain.

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vga_timing_gen.sv | 72 +++++++
 rtl/vga_scanout.sv | 159 +++++++++++++++
 tb/tb_vga_scanout.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, RGB332 field widths and the scanout state type.
package vga_timing_pkg;

   localparam int unsigned VGA_H_VIS  = 640;
   localparam int unsigned VGA_H_FP   = 16;
   localparam int unsigned VGA_H_SYNC = 96;
   localparam int unsigned VGA_H_BP   = 48;
   localparam int unsigned VGA_V_VIS  = 480;
   localparam int unsigned VGA_V_FP   = 10;
   localparam int unsigned VGA_V_SYNC = 2;
   localparam int unsigned VGA_V_BP   = 33;

   localparam int unsigned RGB_R_W = 3;
   localparam int unsigned RGB_G_W = 3;
   localparam int unsigned RGB_B_W = 2;
   localparam int unsigned RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

   typedef enum logic {
      STOP = 1'b0,
      RUN  = 1'b1
   } scanState_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, active window, polarity-applied syncs and frame markers.
// With VGA_SCANOUT_HDOUBLE_EN defined, popSlot_c is high only on even columns.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VIS     = VGA_H_VIS,
   parameter int unsigned H_FP      = VGA_H_FP,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BP      = VGA_H_BP,
   parameter int unsigned V_VIS     = VGA_V_VIS,
   parameter int unsigned V_FP      = VGA_V_FP,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BP      = VGA_V_BP,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic Clk,
   input  logic RstN,
   output logic active_c,
   output logic popSlot_c,
   output logic hSync_c,
   output logic vSync_c,
   output logic frameWrap_c,
   output logic frameStart
);

   localparam int unsigned H_TOTAL    = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL    = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW         = $clog2(H_TOTAL);
   localparam int unsigned VW         = $clog2(V_TOTAL);
   localparam int unsigned H_SYNC_ON  = H_VIS + H_FP;
   localparam int unsigned H_SYNC_OFF = H_SYNC_ON + H_SYNC;
   localparam int unsigned V_SYNC_ON  = V_VIS + V_FP;
   localparam int unsigned V_SYNC_OFF = V_SYNC_ON + V_SYNC;

   logic [HW-1:0] hCount;
   logic [VW-1:0] vCount;
   logic          hWrap_c;
   logic          vWrap_c;

   assign hWrap_c     = (32'(hCount) == H_TOTAL - 1);
   assign vWrap_c     = (32'(vCount) == V_TOTAL - 1);
   assign frameWrap_c = hWrap_c && vWrap_c;

   // Free-running raster; frameStart marks the cycle the counters sit at 0,0 after a wrap
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         hCount     <= '0;
         vCount     <= '0;
         frameStart <= 1'b0;
      end else begin
         frameStart <= frameWrap_c;
         if (hWrap_c) begin
            hCount <= '0;
            vCount <= vWrap_c ? '0 : vCount + VW'(1);
         end else begin
            hCount <= hCount + HW'(1);
         end
      end
   end

   assign active_c = (32'(hCount) < H_VIS) && (32'(vCount) < V_VIS);
   assign hSync_c  = ((32'(hCount) >= H_SYNC_ON) && (32'(hCount) < H_SYNC_OFF)) ? HSYNC_POL : ~HSYNC_POL;
   assign vSync_c  = ((32'(vCount) >= V_SYNC_ON) && (32'(vCount) < V_SYNC_OFF)) ? VSYNC_POL : ~VSYNC_POL;

`ifdef VGA_SCANOUT_HDOUBLE_EN
   assign popSlot_c = ~hCount[0];
`else
   assign popSlot_c = 1'b1;
`endif

endmodule

// File: rtl/vga_scanout.sv
// Pixel-domain FIFO consumer: VGA timing, per-pixel pops, underflow flag, 2-stage output pipe.
// VGA_SCANOUT_HDOUBLE_EN: one pop per even column, each word shown for two pixels.
module vga_scanout
   import vga_timing_pkg::*;
#(
   parameter int unsigned           WWIDTH    = RGB_W,
   parameter int unsigned           H_VIS     = VGA_H_VIS,
   parameter int unsigned           H_FP      = VGA_H_FP,
   parameter int unsigned           H_SYNC    = VGA_H_SYNC,
   parameter int unsigned           H_BP      = VGA_H_BP,
   parameter int unsigned           V_VIS     = VGA_V_VIS,
   parameter int unsigned           V_FP      = VGA_V_FP,
   parameter int unsigned           V_SYNC    = VGA_V_SYNC,
   parameter int unsigned           V_BP      = VGA_V_BP,
   parameter bit                    HSYNC_POL = 1'b0,
   parameter bit                    VSYNC_POL = 1'b0,
   parameter logic [WWIDTH-1:0]     UFL_COLOR = '0
) (
   input  logic              Clk,
   input  logic              RstN,
   input  logic              Enable,
   input  logic [WWIDTH-1:0] FifoData,
   input  logic              FifoEmpty,
   output logic              FifoPop,
   output logic [WWIDTH-1:0] Rgb,
   output logic              HSync,
   output logic              VSync,
   output logic              De,
   output logic              FrameStart,
   output logic              Underflow,
   input  logic              UflClear
);

   scanState_t        state;
   scanState_t        stateNext;
   logic              active_c;
   logic              popSlot_c;
   logic              hSync_c;
   logic              vSync_c;
   logic              frameWrap_c;
   logic              pixRun_c;
   logic              uflSet_c;
   logic [WWIDTH-1:0] pixWord_c;
   logic              s1Run;
   logic              s1Pop;
   logic              s1HSync;
   logic              s1VSync;
`ifdef VGA_SCANOUT_HDOUBLE_EN
   logic              s1Ufl;
   logic [WWIDTH-1:0] holdWord;
`endif

   vga_timing_gen #(
      .H_VIS    (H_VIS),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_VIS    (V_VIS),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .HSYNC_POL(HSYNC_POL),
      .VSYNC_POL(VSYNC_POL)
   ) uTiming (
      .Clk        (Clk),
      .RstN       (RstN),
      .active_c   (active_c),
      .popSlot_c  (popSlot_c),
      .hSync_c    (hSync_c),
      .vSync_c    (vSync_c),
      .frameWrap_c(frameWrap_c),
      .frameStart (FrameStart)
   );

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) state <= STOP;
      else       state <= stateNext;
   end

   // Enable only matters at the frame wrap; underflow never holds the raster
   always_comb begin
      stateNext = state;
      pixRun_c  = 1'b0;
      FifoPop   = 1'b0;
      uflSet_c  = 1'b0;
      case (state)
         STOP: begin
            if (frameWrap_c && Enable) stateNext = RUN;
         end
         RUN: begin
            pixRun_c = active_c;
            FifoPop  = active_c && popSlot_c && !FifoEmpty;
            uflSet_c = active_c && popSlot_c && FifoEmpty;
            if (frameWrap_c && !Enable) stateNext = STOP;
         end
      endcase
   end

   // Stage 1: pixel attributes wait for the FIFO read data
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         s1Run   <= 1'b0;
         s1Pop   <= 1'b0;
         s1HSync <= ~HSYNC_POL;
         s1VSync <= ~VSYNC_POL;
      end else begin
         s1Run   <= pixRun_c;
         s1Pop   <= FifoPop;
         s1HSync <= hSync_c;
         s1VSync <= vSync_c;
      end
   end

   always_comb begin
      pixWord_c = '0;
      if (s1Pop) pixWord_c = FifoData;
`ifdef VGA_SCANOUT_HDOUBLE_EN
      else if (s1Ufl) pixWord_c = UFL_COLOR;
      else if (s1Run) pixWord_c = holdWord;
`else
      else if (s1Run) pixWord_c = UFL_COLOR;
`endif
   end

   // Stage 2: registered pixel outputs
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         Rgb   <= '0;
         De    <= 1'b0;
         HSync <= ~HSYNC_POL;
         VSync <= ~VSYNC_POL;
      end else begin
         Rgb   <= pixWord_c;
         De    <= s1Run;
         HSync <= s1HSync;
         VSync <= s1VSync;
      end
   end

`ifdef VGA_SCANOUT_HDOUBLE_EN
   // Odd columns replay whatever the even column showed, including the underflow colour
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         s1Ufl    <= 1'b0;
         holdWord <= '0;
      end else begin
         s1Ufl <= uflSet_c;
         if (s1Pop || s1Ufl) holdWord <= pixWord_c;
      end
   end
`endif

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN)         Underflow <= 1'b0;
      else if (uflSet_c) Underflow <= 1'b1;
      else if (UflClear) Underflow <= 1'b0;
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a tiny 7x5 raster: directed tables plus randomized traffic
// against a frame-position model driven by cycle count since reset.
`timescale 1ns/1ps
module tb_vga_scanout;

   localparam int unsigned HV = 4, HF = 1, HS = 1, HB = 1;
   localparam int unsigned VV = 2, VF = 1, VS = 1, VB = 1;
   localparam int unsigned HT = HV + HF + HS + HB;
   localparam int unsigned VT = VV + VF + VS + VB;
   localparam int unsigned FT = HT * VT;
   localparam logic [7:0]  UFL = 8'hA5;
`ifdef VGA_SCANOUT_HDOUBLE_EN
   localparam int unsigned POPS_PER_FRAME = 4;
`else
   localparam int unsigned POPS_PER_FRAME = 8;
`endif

   typedef struct {
      logic [7:0] rgb;
      logic       de;
      logic       hs;
      logic       vs;
   } outRec_t;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  rgb;
      logic        de;
   } vec_t;

   logic       Clk = 1'b0;
   logic       RstN;
   logic       Enable;
   logic [7:0] FifoData;
   logic       FifoEmpty;
   logic       FifoPop;
   logic [7:0] Rgb;
   logic       HSync;
   logic       VSync;
   logic       De;
   logic       FrameStart;
   logic       Underflow;
   logic       UflClear;

   int          checks = 0;
   int          errors = 0;
   int unsigned n;
   bit          runFrame;
   bit          uflModel;
   logic [7:0]  lastWord;
   bit          forceEmpty;
   int unsigned popCount = 0;
   outRec_t     expQ[$];
   logic [7:0]  fifoQ[$];
   logic [7:0]  obsRgb[64];
   logic        obsDe[64];
   vec_t        vecs[12];

   always #5 Clk = ~Clk;

   vga_scanout #(
      .WWIDTH(8), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .UFL_COLOR(UFL)
   ) dut (
      .Clk(Clk), .RstN(RstN), .Enable(Enable), .FifoData(FifoData), .FifoEmpty(FifoEmpty),
      .FifoPop(FifoPop), .Rgb(Rgb), .HSync(HSync), .VSync(VSync), .De(De),
      .FrameStart(FrameStart), .Underflow(Underflow), .UflClear(UflClear)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, n);
      end
   endtask

   task automatic modelReset();
      outRec_t r;
      r.rgb = '0; r.de = 1'b0; r.hs = 1'b1; r.vs = 1'b1;
      n        = 0;
      runFrame = 1'b0;
      uflModel = 1'b0;
      lastWord = '0;
      expQ.delete();
      expQ.push_back(r);
      expQ.push_back(r);
   endtask

   // Called just after a negedge; asserts reset mid-cycle, checks async values, releases on a negedge
   task automatic pulseReset(input int holdCycles);
      #2 RstN = 1'b0;
      #1;
      check("rst_rgb",   32'(Rgb),        32'd0);
      check("rst_de",    32'(De),         32'd0);
      check("rst_hsync", 32'(HSync),      32'd1);
      check("rst_vsync", 32'(VSync),      32'd1);
      check("rst_ufl",   32'(Underflow),  32'd0);
      check("rst_pop",   32'(FifoPop),    32'd0);
      check("rst_fs",    32'(FrameStart), 32'd0);
      repeat (holdCycles) @(posedge Clk);
      @(negedge Clk);
      RstN = 1'b1;
      modelReset();
   endtask

   // One pixel clock: expected behaviour comes from raster position n and the FIFO contents
   task automatic doCycle();
      int unsigned h, v;
      bit          act, slot, expPop, uflNow, popped;
      outRec_t     e, o;
      h   = n % HT;
      v   = (n / HT) % VT;
      act = (h < HV) && (v < VV);
`ifdef VGA_SCANOUT_HDOUBLE_EN
      slot = (h % 2) == 0;
`else
      slot = 1'b1;
`endif
      if (n < 64) begin
         obsRgb[n] = Rgb;
         obsDe[n]  = De;
      end
      FifoEmpty = forceEmpty || (fifoQ.size() == 0);
      #1;
      expPop = runFrame && act && slot && !FifoEmpty;
      uflNow = runFrame && act && slot && FifoEmpty;
      check("pop", 32'(FifoPop), 32'(expPop));

      e.de = runFrame && act;
      e.hs = (h >= HV + HF && h < HV + HF + HS) ? 1'b0 : 1'b1;
      e.vs = (v >= VV + VF && v < VV + VF + VS) ? 1'b0 : 1'b1;
      if (!e.de) e.rgb = '0;
      else if (expPop) begin
         e.rgb = fifoQ[0];
         lastWord = e.rgb;
      end else if (uflNow) begin
         e.rgb = UFL;
         lastWord = UFL;
      end else e.rgb = lastWord;
      expQ.push_back(e);

      o = expQ.pop_front();
      check("rgb",   32'(Rgb),        32'(o.rgb));
      check("de",    32'(De),         32'(o.de));
      check("hsync", 32'(HSync),      32'(o.hs));
      check("vsync", 32'(VSync),      32'(o.vs));
      check("ufl",   32'(Underflow),  32'(uflModel));
      check("fstart", 32'(FrameStart), 32'((n > 0) && (n % FT == 0)));

      popped = FifoPop;
      if (popped) popCount++;
      @(posedge Clk);
      #1;
      if (popped && fifoQ.size() > 0) FifoData = fifoQ.pop_front();
      uflModel = uflNow ? 1'b1 : (UflClear ? 1'b0 : uflModel);
      if (h == HT - 1 && v == VT - 1) runFrame = Enable;
      n++;
      @(negedge Clk);
   endtask

   task automatic randomStep();
      if ($urandom_range(0, 40) == 0) Enable = ~Enable;
      forceEmpty = ($urandom_range(0, 9) < 2);
      UflClear   = ($urandom_range(0, 15) == 0);
      if (fifoQ.size() < 4 && $urandom_range(0, 3) != 0) fifoQ.push_back(8'($urandom));
      doCycle();
   endtask

   initial begin
      int unsigned hsLow, vsLow, p0, p1, p2;
      RstN = 1'b0; Enable = 1'b0; FifoEmpty = 1'b1; FifoData = '0; UflClear = 1'b0; forceEmpty = 1'b0;
      n = 0;

`ifdef VGA_SCANOUT_HDOUBLE_EN
      vecs = '{'{36, 8'd0, 1'b0}, '{37, 8'd8, 1'b1}, '{38, 8'd8, 1'b1}, '{39, 8'd9, 1'b1},
               '{40, 8'd9, 1'b1}, '{41, 8'd0, 1'b0}, '{43, 8'd0, 1'b0}, '{44, 8'd10, 1'b1},
               '{45, 8'd10, 1'b1}, '{46, 8'd11, 1'b1}, '{47, 8'd11, 1'b1}, '{48, 8'd0, 1'b0}};
`else
      vecs = '{'{36, 8'd0, 1'b0}, '{37, 8'd8, 1'b1}, '{38, 8'd9, 1'b1}, '{39, 8'd10, 1'b1},
               '{40, 8'd11, 1'b1}, '{41, 8'd0, 1'b0}, '{43, 8'd0, 1'b0}, '{44, 8'd12, 1'b1},
               '{45, 8'd13, 1'b1}, '{46, 8'd14, 1'b1}, '{47, 8'd15, 1'b1}, '{48, 8'd0, 1'b0}};
`endif

      @(negedge Clk);

      // Frame 0 idles in STOP; Enable taken at the wrap, FIFO holds 8..15
      Enable = 1'b1;
      for (int k = 8; k < 16; k++) fifoQ.push_back(8'(k));
      pulseReset(2);
      hsLow = 0; vsLow = 0; popCount = 0; p0 = 0;
      for (int i = 0; i < 50; i++) begin
         if (i >= 2 && i < 37) begin
            if (HSync == 1'b0) hsLow++;
            if (VSync == 1'b0) vsLow++;
         end
         if (i == 35) p0 = popCount;
         doCycle();
      end
      check("stop_hs_low", hsLow, 32'd5);
      check("stop_vs_low", vsLow, 32'd7);
      check("stop_pops", p0, 32'd0);
      check("run_pops", popCount - p0, POPS_PER_FRAME);
      for (int i = 0; i < 12; i++) begin
         check("tbl_rgb", 32'(obsRgb[vecs[i].cyc]), 32'(vecs[i].rgb));
         check("tbl_de",  32'(obsDe[vecs[i].cyc]),  32'(vecs[i].de));
      end

      // Underflow at the 3rd active pixel of line 0, then clear; reset lands mid-line
      fifoQ.delete();
      for (int k = 20; k < 40; k++) fifoQ.push_back(8'(k));
      pulseReset(1);
      for (int i = 0; i < 46; i++) begin
         forceEmpty = (n == 37);
         UflClear   = (n == 42);
         if (n == 37) check("ufl_before", 32'(Underflow), 32'd0);
         if (n == 38) check("ufl_set",    32'(Underflow), 32'd1);
         if (n == 42) check("ufl_sticky", 32'(Underflow), 32'd1);
         if (n == 43) check("ufl_clear",  32'(Underflow), 32'd0);
         doCycle();
      end
      forceEmpty = 1'b0;
      UflClear   = 1'b0;
`ifdef VGA_SCANOUT_HDOUBLE_EN
      check("ufl_rgb38", 32'(obsRgb[38]), 32'd20);
      check("ufl_rgb39", 32'(obsRgb[39]), 32'(UFL));
      check("ufl_rgb40", 32'(obsRgb[40]), 32'(UFL));
      check("ufl_rgb44", 32'(obsRgb[44]), 32'd21);
`else
      check("ufl_rgb38", 32'(obsRgb[38]), 32'd21);
      check("ufl_rgb39", 32'(obsRgb[39]), 32'(UFL));
      check("ufl_rgb40", 32'(obsRgb[40]), 32'd22);
      check("ufl_rgb44", 32'(obsRgb[44]), 32'd23);
`endif
      check("pre_rst_de", 32'(De), 32'd1);
      pulseReset(1);

      // Enable dropped mid-frame: current frame completes, next frame pops nothing
      fifoQ.delete();
      for (int k = 40; k < 80; k++) fifoQ.push_back(8'(k));
      Enable = 1'b1;
      p0 = 0; p1 = 0;
      for (int i = 0; i < 105; i++) begin
         if (n == 40) Enable = 1'b0;
         if (n == 35) p0 = popCount;
         if (n == 70) p1 = popCount;
         doCycle();
      end
      p2 = popCount;
      check("drop_frame_pops", p1 - p0, POPS_PER_FRAME);
      check("after_drop_pops", p2 - p1, 32'd0);

      // Randomized traffic with mid-line resets between segments
      Enable = 1'b1;
      for (int seg = 0; seg < 3; seg++) begin
         for (int i = 0; i < 400; i++) randomStep();
         for (int k = 0; k < int'(HT) && (n % HT) != 2; k++) randomStep();
         forceEmpty = 1'b0;
         UflClear   = 1'b0;
         pulseReset(1 + seg);
      end
      for (int i = 0; i < 100; i++) randomStep();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
